pe_cfg_loader: RTL and testbench
================================

Name: pe_cfg_loader

Overview:
- Synthesizable configuration sequencer for a single PE (e.g. the MUL PE).
- Holds a small table of pattern-entry configs written by a host.
- On start, streams the configs in address order as config packets into one of the PE's ingress FIFOs, then raises init_done.
- Sits between the host/CSR path and the PE's ingress FIFO; needs no testbench to bring up the PE.

Parameters:
- DEPTH, 16, table entries; max 16, since pat_ind is 4 bits.
- X_COORD, 2'b00, x_coord field placed in every config payload.
- Y_COORD, 2'b00, y_coord field placed in every config payload.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a load sequence; single-cycle pulse.
- cnt  in  5  number of entries to send, sampled on accepted start; values above DEPTH clamp to DEPTH.
- tbl_we  in  1  table write enable.
- tbl_addr  in  4  table write address.
- tbl_wdata  in  $bits(pe_cfg_entry_t)  entry to write.
- out_enq  out  1  enqueue strobe to the PE ingress FIFO.
- out_wdata  out  36  config packet (packet_t).
- out_full  in  1  FIFO full.
- busy  out  1  state==SEND.
- init_done  out  1  sequence complete.
- sent_cnt  out  5  packets sent in the current or last sequence.

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high, and forces state IDLE, idx=0, sent_cnt=0, init_done=0, busy=0, out_enq=0. Table contents are not reset.
- States: IDLE, SEND, DONE.
- IDLE/DONE + start: latch min(cnt,DEPTH) into len, idx=0, sent_cnt=0, init_done=0.
  - Next state is SEND if len>0.
  - If len==0, next state is DONE and init_done=1 on the next cycle.
- Packet format: out_wdata is combinational from table[idx].
  - pid=0, padding=0, x_coord=X_COORD, y_coord=Y_COORD.
  - pat_ind and pat_w_entry come from the entry.
- SEND handshake: out_enq = (state==SEND) && !out_full, combinational. A packet is transferred in each cycle where out_enq=1.
  - On transfer: idx++, sent_cnt++.
  - On the transfer with idx==len-1: next state DONE, init_done=1 from the next cycle.
  - Throughput is 1 packet/cycle while out_full=0.
  - If out_full=1, hold idx and stall indefinitely. There is no timeout.
- DONE: init_done stays 1 until the next accepted start or rst. out_enq=0.
- start while in SEND: ignored, no effect.
- Table writes:
  - Committed at the clock edge when tbl_we=1 and state!=SEND.
  - Writes in SEND are dropped silently, so the sent sequence is never corrupted.
  - Same-cycle tbl_we and start in IDLE: the write commits, and the first transmitted packet (earliest next cycle) sees the new data.
- Reset mid-SEND: the sequence aborts. A packet transferred in the reset cycle is not undone. Return to IDLE with init_done=0.
- Latency: start at cycle t gives the first out_enq at t+1 (when not full). init_done rises one cycle after the last transfer.

Optional Feature:
- Macro: PE_CFG_GAP_EN.
- When defined: after each transfer, the loader spends one mandatory idle cycle (out_enq=0) before the next packet, giving 1 packet per 2 cycles. This matches the pacing of the bench send task. The last packet is not followed by a gap; init_done still rises one cycle after the last transfer.
- When undefined: back-to-back transfers as above.

Decomposition:
- Into pe_types (shared package):
  - pe_cfg_entry_t = {pat_ind[3:0], pattern-entry struct: the type of config_payload_t.pat_w_entry}.
  - State enum pe_cfg_state_t {IDLE, SEND, DONE}.
- Reuse packet_t and config_payload_t from pe_types.
- Sub-module: pe_cfg_table, a DEPTH-entry register file with one write port and one combinational read port. The FSM stays in pe_cfg_loader.

Test Plan:
- Basic load: write 5 entries (pat_ind 11..15, ops mul/mul/mul_h/mul_hsu/mul_hu, pid 11..15); start, cnt=5, out_full=0 -> 5 consecutive out_enq cycles starting the cycle after start, pat_ind 11..15 in order, pid=0; init_done=1 the cycle after the 5th; sent_cnt=5.
- Back-pressure: cnt=3, out_full held 1 for 4 cycles after the first transfer -> no enq during the hold, idx held, packets 1,2 resume after; 3 packets total, order intact.
- Edge counts:
  - cnt=0 -> DONE with init_done=1 one cycle after start, no out_enq.
  - cnt=20 -> clamps to 16 packets.
- Ignored events in SEND: tbl_we to addr 1 mid-SEND before packet 1 is sent -> packet 1 carries the old value. Second start mid-SEND -> ignored; sent_cnt ends at the original cnt.
- Reset mid-operation: rst after 2 of 5 transfers -> next cycle out_enq=0, init_done=0, sent_cnt=0, IDLE. A new start resends from entry 0.
- PE_CFG_GAP_EN defined, cnt=4, out_full=0 -> enq at t+1, t+3, t+5, t+7; init_done at t+8.

Source files
------------

// File: rtl/pe_types.sv
// Shared PE types: pattern entries, config packets and the config-loader state encoding.
package pe_types;

   typedef enum logic [2:0] {
      OpMul    = 3'd0,
      OpMulH   = 3'd1,
      OpMulHsu = 3'd2,
      OpMulHu  = 3'd3
   } pe_op_t;

   typedef struct packed {
      pe_op_t     op;
      logic [3:0] pid;
      logic [7:0] arg;
   } pat_entry_t;

   typedef struct packed {
      logic [8:0] padding;
      logic [3:0] pat_ind;
      pat_entry_t pat_w_entry;
   } config_payload_t;

   typedef struct packed {
      logic [3:0]      pid;
      logic [1:0]      x_coord;
      logic [1:0]      y_coord;
      config_payload_t payload;
   } packet_t;

   typedef struct packed {
      logic [3:0] pat_ind;
      pat_entry_t pat_w_entry;
   } pe_cfg_entry_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } pe_cfg_state_t;

   // Config packets always target pid 0 with zero padding.
   function automatic packet_t cfg_packet(pe_cfg_entry_t e, logic [1:0] x, logic [1:0] y);
      packet_t p;
      p                     = '0;
      p.x_coord             = x;
      p.y_coord             = y;
      p.payload.pat_ind     = e.pat_ind;
      p.payload.pat_w_entry = e.pat_w_entry;
      return p;
   endfunction

endpackage

// File: rtl/pe_cfg_table.sv
// DEPTH-entry config register file: one synchronous write port, one combinational read port.
module pe_cfg_table
   import pe_types::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [3:0]    i_waddr,
   input  pe_cfg_entry_t i_wdata,
   input  logic [3:0]    i_raddr,
   output pe_cfg_entry_t o_rdata
);

   pe_cfg_entry_t r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we && (32'(i_waddr) < DEPTH)) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = (32'(i_raddr) < DEPTH) ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/pe_cfg_loader.sv
// Streams a host-written config table into a PE ingress FIFO, then raises init_done.
// Optional PE_CFG_GAP_EN inserts one idle cycle after every non-final transfer.
module pe_cfg_loader
   import pe_types::*;
#(
   parameter int unsigned DEPTH   = 16,
   parameter logic [1:0]  X_COORD = 2'b00,
   parameter logic [1:0]  Y_COORD = 2'b00
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_start,
   input  logic [4:0]    i_cnt,
   input  logic          i_tbl_we,
   input  logic [3:0]    i_tbl_addr,
   input  pe_cfg_entry_t i_tbl_wdata,
   output logic          o_out_enq,
   output packet_t       o_out_wdata,
   input  logic          i_out_full,
   output logic          o_busy,
   output logic          o_init_done,
   output logic [4:0]    o_sent_cnt
);

   localparam logic [4:0] DepthC = 5'(DEPTH);

   pe_cfg_state_t r_state;
   logic [4:0]    r_idx;
   logic [4:0]    r_len;
   logic [4:0]    r_sent;
   logic          r_done;

   logic [4:0]    w_len;
   logic          w_last;
   logic          w_pace_ok;
   pe_cfg_entry_t w_entry;

   assign w_len  = (i_cnt > DepthC) ? DepthC : i_cnt;
   assign w_last = (r_idx == (r_len - 5'd1));

`ifdef PE_CFG_GAP_EN
   logic r_gap;
   assign w_pace_ok = !r_gap;
`else
   assign w_pace_ok = 1'b1;
`endif

   // Writes during SEND are dropped so an in-flight sequence stays consistent.
   pe_cfg_table #(
      .DEPTH (DEPTH)
   ) u_table (
      .i_clk   (i_clk),
      .i_we    (i_tbl_we && (r_state != SEND)),
      .i_waddr (i_tbl_addr),
      .i_wdata (i_tbl_wdata),
      .i_raddr (r_idx[3:0]),
      .o_rdata (w_entry)
   );

   assign o_out_enq   = (r_state == SEND) && !i_out_full && w_pace_ok;
   assign o_out_wdata = cfg_packet(w_entry, X_COORD, Y_COORD);
   assign o_busy      = (r_state == SEND);
   assign o_init_done = r_done;
   assign o_sent_cnt  = r_sent;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_len   <= '0;
         r_sent  <= '0;
         r_done  <= 1'b0;
`ifdef PE_CFG_GAP_EN
         r_gap   <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            IDLE, DONE: begin
               if (i_start) begin
                  r_len   <= w_len;
                  r_idx   <= '0;
                  r_sent  <= '0;
                  r_done  <= (w_len == 5'd0);
                  r_state <= (w_len == 5'd0) ? DONE : SEND;
`ifdef PE_CFG_GAP_EN
                  r_gap   <= 1'b0;
`endif
               end
            end
            SEND: begin
               if (o_out_enq) begin
                  r_idx  <= r_idx + 5'd1;
                  r_sent <= r_sent + 5'd1;
                  if (w_last) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end
               end
`ifdef PE_CFG_GAP_EN
               r_gap <= o_out_enq && !w_last;
`endif
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pe_cfg_loader.sv
// Self-checking bench for pe_cfg_loader: directed steps plus randomized sequences vs a packet-queue model.
module tb_pe_cfg_loader;
   import pe_types::*;

   localparam int unsigned DEPTH = 16;
   localparam logic [1:0]  XC    = 2'b10;
   localparam logic [1:0]  YC    = 2'b01;
   localparam int          EW    = $bits(pe_cfg_entry_t);
`ifdef PE_CFG_GAP_EN
   localparam bit GAP = 1'b1;
`else
   localparam bit GAP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, start, tbl_we, out_full;
   logic [4:0]    cnt_i;
   logic [3:0]    tbl_addr;
   pe_cfg_entry_t tbl_wdata;
   logic          out_enq, busy, init_done;
   packet_t       out_wdata;
   logic [4:0]    sent_cnt;

   int n_chk  = 0;
   int n_fail = 0;
   pe_cfg_entry_t model [DEPTH];

   always #5 clk = ~clk;

   pe_cfg_loader #(
      .DEPTH   (DEPTH),
      .X_COORD (XC),
      .Y_COORD (YC)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_cnt       (cnt_i),
      .i_tbl_we    (tbl_we),
      .i_tbl_addr  (tbl_addr),
      .i_tbl_wdata (tbl_wdata),
      .o_out_enq   (out_enq),
      .o_out_wdata (out_wdata),
      .i_out_full  (out_full),
      .o_busy      (busy),
      .o_init_done (init_done),
      .o_sent_cnt  (sent_cnt)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic packet_t exp_pkt(input pe_cfg_entry_t e);
      packet_t p;
      p.pid                 = 4'd0;
      p.x_coord             = XC;
      p.y_coord             = YC;
      p.payload.padding     = 9'd0;
      p.payload.pat_ind     = e.pat_ind;
      p.payload.pat_w_entry = e.pat_w_entry;
      return p;
   endfunction

   function automatic pe_cfg_entry_t rand_entry();
      logic [31:0] r;
      r = $urandom;
      return pe_cfg_entry_t'(r[EW-1:0]);
   endfunction

   function automatic pe_cfg_entry_t mk_entry(input int ind, input pe_op_t op, input int pid);
      pe_cfg_entry_t e;
      logic [31:0]   r;
      r                 = $urandom;
      e.pat_ind         = 4'(ind);
      e.pat_w_entry.op  = op;
      e.pat_w_entry.pid = 4'(pid);
      e.pat_w_entry.arg = r[7:0];
      return e;
   endfunction

   // Called just after a rising edge while the loader is not sending.
   task automatic wr(input int a, input pe_cfg_entry_t e);
      tbl_we    = 1'b1;
      tbl_addr  = 4'(a);
      tbl_wdata = e;
      @(posedge clk); #1;
      tbl_we    = 1'b0;
      model[a]  = e;
   endtask

   // fmode: 0 never full, 1 full for 4 cycles after the first transfer, 2 random.
   task automatic run_seq(input int cnt, input int fmode, input int we_cyc, input int st_cyc,
                          input bit wr_at_start);
      int      len, sent;
      bit      gap_prev, full, enq_exp, was_done, fin;
      packet_t q[$];
      pe_cfg_entry_t ne;
      len   = (cnt > int'(DEPTH)) ? int'(DEPTH) : cnt;
      start = 1'b1;
      cnt_i = 5'(cnt);
      if (wr_at_start) begin
         ne        = rand_entry();
         tbl_we    = 1'b1;
         tbl_addr  = 4'd0;
         tbl_wdata = ne;
         model[0]  = ne;
      end
      @(negedge clk);
      check("enq_before_start", 64'(out_enq), 64'd0);
      @(posedge clk); #1;
      start  = 1'b0;
      tbl_we = 1'b0;
      for (int i = 0; i < len; i++) q.push_back(exp_pkt(model[i]));
      sent     = 0;
      gap_prev = 1'b0;
      fin      = 1'b0;
      for (int k = 1; k <= 400 && !fin; k++) begin
         case (fmode)
            0:       full = 1'b0;
            1:       full = (k >= 2) && (k <= 5);
            default: full = (k == 1) ? 1'b0 : 1'($urandom_range(0, 1));
         endcase
         out_full = full;
         if (k == we_cyc) begin
            tbl_we    = 1'b1;
            tbl_addr  = 4'd1;
            tbl_wdata = rand_entry();
         end
         if (k == st_cyc) begin
            start = 1'b1;
            cnt_i = 5'd7;
         end
         @(negedge clk);
         was_done = (sent == len);
         enq_exp  = (sent < len) && !full && !(GAP && gap_prev);
         check("busy", 64'(busy), 64'(sent < len));
         check("out_enq", 64'(out_enq), 64'(enq_exp));
         check("sent_cnt", 64'(sent_cnt), 64'(sent));
         check("init_done", 64'(init_done), 64'(was_done));
         if (enq_exp) begin
            check("out_wdata", 64'(out_wdata), 64'(q[sent]));
            sent++;
         end
         gap_prev = enq_exp;
         if (was_done) fin = 1'b1;
         @(posedge clk); #1;
         tbl_we   = 1'b0;
         start    = 1'b0;
         out_full = 1'b0;
      end
      if (!fin) check("seq_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      pe_cfg_entry_t old1;
      rst       = 1'b1;
      start     = 1'b0;
      cnt_i     = '0;
      tbl_we    = 1'b0;
      tbl_addr  = '0;
      tbl_wdata = '0;
      out_full  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_enq", 64'(out_enq), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(init_done), 64'd0);
      check("rst_sent", 64'(sent_cnt), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int a = 0; a < int'(DEPTH); a++) wr(a, rand_entry());

      // Basic load of five MUL pattern entries.
      wr(0, mk_entry(11, OpMul, 11));
      wr(1, mk_entry(12, OpMul, 12));
      wr(2, mk_entry(13, OpMulH, 13));
      wr(3, mk_entry(14, OpMulHsu, 14));
      wr(4, mk_entry(15, OpMulHu, 15));
      run_seq(5, 0, 0, 0, 1'b0);
      check("basic_sent_final", 64'(sent_cnt), 64'd5);

      // Back-pressure held for four cycles after the first transfer.
      run_seq(3, 1, 0, 0, 1'b0);

      // Zero-length and clamped sequences.
      run_seq(0, 0, 0, 0, 1'b0);
      run_seq(20, 2, 0, 0, 1'b0);
      check("clamp_sent_final", 64'(sent_cnt), 64'd16);

      // Write and second start during SEND are both ignored.
      old1 = model[1];
      run_seq(4, 0, 1, 2, 1'b0);
      check("drop_write_model", 64'(model[1]), 64'(old1));
      check("ignored_start_sent", 64'(sent_cnt), 64'd4);
      run_seq(2, 0, 0, 0, 1'b0);

      // Reset after two of five transfers.
      start = 1'b1;
      cnt_i = 5'd5;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      if (GAP) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      check("pre_rst_sent", 64'(sent_cnt), 64'd2);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_enq", 64'(out_enq), 64'd0);
      check("mid_rst_done", 64'(init_done), 64'd0);
      check("mid_rst_sent", 64'(sent_cnt), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      run_seq(5, 0, 0, 0, 1'b0);

      // Same-cycle table write and start from DONE.
      run_seq(3, 0, 0, 0, 1'b1);

      // Randomized sequences with table updates in between.
      for (int it = 0; it < 8; it++) begin
         for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
            wr(int'($urandom_range(0, DEPTH - 1)), rand_entry());
         end
         run_seq(int'($urandom_range(0, 20)), 2, 0, 0, 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
